knn_cluster1_mul_arb: RTL

- Round-robin arbiter and pipeline sequencer that shares one unsigned 17x15 multiplier among NUM_REQ requesters in the knn_cluster1 datapath.
- Accepts at most one operand pair per cycle and pushes it through a LATENCY-stage registered multiply.
- Returns each product to its originating requester with a one-hot response strobe.
- Replaces per-requester multiplier instances where DSP count is the constraint.

---
 rtl/knn_cluster1_mul_arb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/knn_cluster1_mul_arb.sv
// -----------------------------------------------------------------------------
// knn_cluster1_mul_arb
//
// Purpose:
//   Shares one unsigned A_WIDTH x B_WIDTH multiplier among NUM_REQ requesters.
//   A round-robin arbiter accepts at most one operand pair per cycle and pushes
//   it through a LATENCY-stage registered multiply. The product returns to the
//   requester that issued it, in accept order, with a one-cycle one-hot strobe.
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst     in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]          per-requester operand valid
//   req_ready  out  [NUM_REQ]          one-hot grant (transfer = valid & ready)
//   req_a      in   [NUM_REQ*A_WIDTH]  packed operand a, requester i at i*A_WIDTH
//   req_b      in   [NUM_REQ*B_WIDTH]  packed operand b, requester i at i*B_WIDTH
//   rsp_valid  out  [NUM_REQ]          one-hot result strobe to the originator
//   rsp_p      out  [P_WIDTH]          product; holds its last value when idle
//   busy       out                     any request pending or any stage occupied
// -----------------------------------------------------------------------------
module knn_cluster1_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 17,
  parameter int B_WIDTH = 15,
  parameter int P_WIDTH = 32,
  parameter int LATENCY = 3
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FULL_W = A_WIDTH + B_WIDTH;
  // Stage that first holds the product: stage 1 when LATENCY is 1, else
  // stage 1 holds the operands and stage 2 holds the product.
  localparam int PS     = (LATENCY == 1) ? 1 : 2;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  // Arbiter state and signals
  logic [IDX_W-1:0]   r_last_grant;
  logic [A_WIDTH-1:0] w_a [NUM_REQ];
  logic [B_WIDTH-1:0] w_b [NUM_REQ];
  logic               w_gnt_found;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_xfer;
  logic [A_WIDTH-1:0] w_sel_a;
  logic [B_WIDTH-1:0] w_sel_b;

  // Pipeline state
  logic               r_vld [1:LATENCY];
  logic [IDX_W-1:0]   r_tag [1:LATENCY];
  logic [P_WIDTH-1:0] r_p   [PS:LATENCY];
  logic [FULL_W-1:0]  w_full;
  logic [P_WIDTH-1:0] w_prod;
  logic               w_prod_en;
  logic               w_pipe_busy;

  // Unpack the flat operand buses so the grant index can select directly.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a[gi] = req_a[gi*A_WIDTH +: A_WIDTH];
      assign w_b[gi] = req_b[gi*B_WIDTH +: B_WIDTH];
    end
  endgenerate

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = 0;
    w_cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand     = (int'(r_last_grant) + off) % NUM_REQ;
      w_cand_idx = IDX_W'(w_cand);
      if (!w_gnt_found && req_valid[w_cand_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand_idx;
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    if (w_gnt_found) begin
      w_gnt_oh[w_gnt_idx] = 1'b1;
    end
  end

  // Grants are suppressed while reset is held, even though reset is async,
  // so no requester sees a handshake that the pipeline will not capture.
  assign w_xfer    = w_gnt_found & ~ap_rst;
  assign req_ready = ap_rst ? '0 : w_gnt_oh;
  assign w_sel_a   = w_a[w_gnt_idx];
  assign w_sel_b   = w_b[w_gnt_idx];

  // Pointer plus valid/tag chain. The tag only moves with a valid entry so
  // idle cycles do not disturb it.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_last_grant <= LAST_RST;
      for (int s = 1; s <= LATENCY; s++) begin
        r_vld[s] <= 1'b0;
        r_tag[s] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_last_grant <= w_gnt_idx;
        r_tag[1]     <= w_gnt_idx;
      end
      r_vld[1] <= w_xfer;
      for (int s = 2; s <= LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_tag[s] <= r_tag[s-1];
        end
      end
    end
  end

  // Multiply source: the live granted operands when the product must be
  // registered in stage 1, otherwise the stage-1 operand registers.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_full    = FULL_W'(w_sel_a) * FULL_W'(w_sel_b);
      assign w_prod_en = w_xfer;
    end else begin : g_latn
      logic [A_WIDTH-1:0] r_a;
      logic [B_WIDTH-1:0] r_b;

      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_xfer) begin
          r_a <= w_sel_a;
          r_b <= w_sel_b;
        end
      end

      assign w_full    = FULL_W'(r_a) * FULL_W'(r_b);
      assign w_prod_en = r_vld[1];
    end
  endgenerate

  // Truncates or zero-extends the full-width product to P_WIDTH.
  assign w_prod = P_WIDTH'(w_full);

  // Product data registers only load behind a valid entry, which makes the
  // last stage hold the most recent product between responses.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int s = PS; s <= LATENCY; s++) begin
        r_p[s] <= '0;
      end
    end else begin
      if (w_prod_en) begin
        r_p[PS] <= w_prod;
      end
      for (int s = PS + 1; s <= LATENCY; s++) begin
        if (r_vld[s-1]) begin
          r_p[s] <= r_p[s-1];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_vld[LATENCY]) begin
      rsp_valid[r_tag[LATENCY]] = 1'b1;
    end
  end

  assign rsp_p = r_p[LATENCY];

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int s = 1; s <= LATENCY; s++) begin
      w_pipe_busy = w_pipe_busy | r_vld[s];
    end
  end

  assign busy = (|req_valid) | w_pipe_busy;

endmodule
